// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EX and WB.
// Holds one instruction from EX. If that instruction issued a data-bus
// request, the stage waits for data_sram_data_ok. It then aligns and extends
// load data (including the LWL/LWR merge with the old rt value) and produces
// a 4-bit byte write strobe for write-back.
//
// Ports:
//   clk, resetn           clock, asynchronous active-low reset
//   ws_allowin            WB can accept an instruction
//   ms_allowin            this stage can accept from EX
//   es_to_ms_valid/_bus   instruction offered by EX (108-bit bus)
//   data_sram_data_ok     data-bus response strobe
//   data_sram_rdata       read data, valid with data_ok
//   ms_to_ws_valid/_bus   {gr_we[3:0], dest, final_result, pc} to WB
//   stall_ms_bus          {valid && |gr_we, dest} to decode
//   forward_ms_bus        {valid && ready_go, final_result} to decode
module mem_stage (
   input  logic         clk,
   input  logic         resetn,
   input  logic         ws_allowin,
   output logic         ms_allowin,
   input  logic         es_to_ms_valid,
   input  logic [107:0] es_to_ms_bus,
   input  logic         data_sram_data_ok,
   input  logic [31:0]  data_sram_rdata,
   output logic         ms_to_ws_valid,
   output logic [72:0]  ms_to_ws_bus,
   output logic [5:0]   stall_ms_bus,
   output logic [32:0]  forward_ms_bus
);

   logic         ms_valid_q, ms_valid_d;
   logic         buf_valid_q, buf_valid_d;
   logic [31:0]  rdata_buf_q, rdata_buf_d;
   logic [107:0] ms_bus_q, ms_bus_d;

   logic [2:0]   load_op_s;
   logic         mem_req_s;
   logic [1:0]   addr_lo_s;
   logic         gr_we_s;
   logic [4:0]   dest_s;
   logic [31:0]  alu_result_s, rt_value_s, pc_s;

   logic         ms_ready_go_s, leave_s, buf_set_s;
   logic [31:0]  rd_s, result_s;
   logic [7:0]   byte_s;
   logic [15:0]  half_s;
   logic [3:0]   strobe_s, wb_we_s;

   assign {load_op_s, mem_req_s, addr_lo_s, gr_we_s, dest_s,
           alu_result_s, rt_value_s, pc_s} = ms_bus_q;

   // A buffered response counts as arrived; non-memory ops never wait.
   assign ms_ready_go_s  = !mem_req_s || data_sram_data_ok || buf_valid_q;
   assign ms_allowin     = !ms_valid_q || (ms_ready_go_s && ws_allowin);
   assign ms_to_ws_valid = ms_valid_q && ms_ready_go_s;
   assign leave_s        = ms_valid_q && ms_ready_go_s && ws_allowin;
   // Capture only a fresh response that WB cannot take this cycle.
   assign buf_set_s      = ms_valid_q && mem_req_s && data_sram_data_ok &&
                           !buf_valid_q && !ws_allowin;

   assign rd_s   = buf_valid_q ? rdata_buf_q : data_sram_rdata;
   assign half_s = addr_lo_s[1] ? rd_s[31:16] : rd_s[15:0];

   // Next-state for valid, response buffer and payload.
   always_comb begin
      buf_valid_d = buf_valid_q;
      rdata_buf_d = rdata_buf_q;
      if (leave_s) begin
         buf_valid_d = 1'b0;
      end else if (buf_set_s) begin
         buf_valid_d = 1'b1;
         rdata_buf_d = data_sram_rdata;
      end else begin
         buf_valid_d = buf_valid_q;
      end
      if (ms_allowin) begin
         ms_valid_d = es_to_ms_valid;
      end else begin
         ms_valid_d = ms_valid_q;
      end
      if (es_to_ms_valid && ms_allowin) begin
         ms_bus_d = es_to_ms_bus;
      end else begin
         ms_bus_d = ms_bus_q;
      end
   end

   // Byte lane selected by the low address bits.
   always_comb begin
      byte_s = rd_s[7:0];
      case (addr_lo_s)
         2'd0:    byte_s = rd_s[7:0];
         2'd1:    byte_s = rd_s[15:8];
         2'd2:    byte_s = rd_s[23:16];
         2'd3:    byte_s = rd_s[31:24];
         default: byte_s = rd_s[7:0];
      endcase
   end

   // Load alignment, extension and LWL/LWR merge with write strobe.
   always_comb begin
      result_s = alu_result_s;
      strobe_s = 4'b1111;
      case (load_op_s)
         3'd0: result_s = alu_result_s;
         3'd1: result_s = {{24{byte_s[7]}}, byte_s};
         3'd2: result_s = {24'd0, byte_s};
         3'd3: result_s = {{16{half_s[15]}}, half_s};
         3'd4: result_s = {16'd0, half_s};
         3'd5: result_s = rd_s;
         3'd6: begin
            case (addr_lo_s)
               2'd0:    begin result_s = {rd_s[7:0],  rt_value_s[23:0]}; strobe_s = 4'b1000; end
               2'd1:    begin result_s = {rd_s[15:0], rt_value_s[15:0]}; strobe_s = 4'b1100; end
               2'd2:    begin result_s = {rd_s[23:0], rt_value_s[7:0]};  strobe_s = 4'b1110; end
               default: begin result_s = rd_s;                           strobe_s = 4'b1111; end
            endcase
         end
         3'd7: begin
            case (addr_lo_s)
               2'd0:    begin result_s = rd_s;                             strobe_s = 4'b1111; end
               2'd1:    begin result_s = {rt_value_s[31:24], rd_s[31:8]};  strobe_s = 4'b0111; end
               2'd2:    begin result_s = {rt_value_s[31:16], rd_s[31:16]}; strobe_s = 4'b0011; end
               default: begin result_s = {rt_value_s[31:8],  rd_s[31:24]}; strobe_s = 4'b0001; end
            endcase
         end
         default: result_s = alu_result_s;
      endcase
   end

   assign wb_we_s        = strobe_s & {4{gr_we_s}};
   assign ms_to_ws_bus   = {wb_we_s, dest_s, result_s, pc_s};
   assign stall_ms_bus   = {ms_valid_q && (|wb_we_s), dest_s};
   assign forward_ms_bus = {ms_valid_q && ms_ready_go_s, result_s};

   // Control state: cleared asynchronously so an outstanding request is dropped.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ms_valid_q  <= 1'b0;
         buf_valid_q <= 1'b0;
      end else begin
         ms_valid_q  <= ms_valid_d;
         buf_valid_q <= buf_valid_d;
      end
   end

   // Payload and response buffer: data only, qualified by the valid flags.
   always_ff @(posedge clk) begin
      ms_bus_q    <= ms_bus_d;
      rdata_buf_q <= rdata_buf_d;
   end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

   logic         clk = 1'b0;
   logic         resetn;
   logic         ws_allowin;
   logic         ms_allowin;
   logic         es_to_ms_valid;
   logic [107:0] es_to_ms_bus;
   logic         data_sram_data_ok;
   logic [31:0]  data_sram_rdata;
   logic         ms_to_ws_valid;
   logic [72:0]  ms_to_ws_bus;
   logic [5:0]   stall_ms_bus;
   logic [32:0]  forward_ms_bus;

   int checks = 0;
   int errors = 0;

   // behavioural model: the instruction held, whether its response arrived
   logic         m_valid;
   logic         m_got;
   logic [31:0]  m_data;
   logic [107:0] m_ins;

   always #5 clk = ~clk;

   mem_stage u_dut (
      .clk               (clk),
      .resetn            (resetn),
      .ws_allowin        (ws_allowin),
      .ms_allowin        (ms_allowin),
      .es_to_ms_valid    (es_to_ms_valid),
      .es_to_ms_bus      (es_to_ms_bus),
      .data_sram_data_ok (data_sram_data_ok),
      .data_sram_rdata   (data_sram_rdata),
      .ms_to_ws_valid    (ms_to_ws_valid),
      .ms_to_ws_bus      (ms_to_ws_bus),
      .stall_ms_bus      (stall_ms_bus),
      .forward_ms_bus    (forward_ms_bus)
   );

   task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [107:0] mk(input logic [2:0] op, input logic req, input logic [1:0] alo,
                                       input logic gwe, input logic [4:0] dest, input logic [31:0] alu,
                                       input logic [31:0] rt, input logic [31:0] pc);
      return {op, req, alo, gwe, dest, alu, rt, pc};
   endfunction

   // {strobe, result} from the load rules, using shifts and masks
   function automatic logic [35:0] model_out(input logic [107:0] ins, input logic [31:0] rd);
      logic [2:0]  op;
      int          a;
      int          n;
      logic [31:0] rt, res, b, h;
      logic [3:0]  st;
      op  = ins[107:105];
      a   = int'(ins[103:102]);
      rt  = ins[63:32];
      b   = (rd >> (8 * a)) & 32'h0000_00FF;
      h   = (rd >> (16 * (a / 2))) & 32'h0000_FFFF;
      st  = 4'hF;
      res = ins[95:64];
      case (op)
         3'd1: res = (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
         3'd2: res = b;
         3'd3: res = (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
         3'd4: res = h;
         3'd5: res = rd;
         3'd6: begin
            n   = 8 * (3 - a);
            res = (rd << n) | (rt & ((32'd1 << n) - 32'd1));
            st  = 4'(4'hF << (3 - a));
         end
         3'd7: begin
            n   = 8 * a;
            res = (rd >> n) | (rt & ~(32'hFFFF_FFFF >> n));
            st  = 4'(4'hF >> a);
         end
         default: res = ins[95:64];
      endcase
      return {st, res};
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m_got   = 1'b0;
   endtask

   // compare every DUT output against the model for the current inputs
   task automatic check_model();
      logic        rg, ov, gwe;
      logic [31:0] rd;
      logic [35:0] mo;
      logic [3:0]  gw;
      rg  = !m_ins[104] || data_sram_data_ok || m_got;
      ov  = m_valid && rg;
      gwe = m_ins[101];
      chk("allowin", 73'(ms_allowin), 73'(!m_valid || (rg && ws_allowin)));
      chk("out_valid", 73'(ms_to_ws_valid), 73'(ov));
      chk("stall_v", 73'(stall_ms_bus[5]), 73'(m_valid && gwe));
      chk("fwd_v", 73'(forward_ms_bus[32]), 73'(ov));
      if (m_valid) begin
         chk("stall_dest", 73'(stall_ms_bus[4:0]), 73'(m_ins[100:96]));
      end
      if (ov) begin
         rd = m_got ? m_data : data_sram_rdata;
         mo = model_out(m_ins, rd);
         gw = gwe ? mo[35:32] : 4'h0;
         chk("ws_bus", ms_to_ws_bus, {gw, m_ins[100:96], mo[31:0], m_ins[31:0]});
         chk("fwd_data", 73'(forward_ms_bus[31:0]), 73'(mo[31:0]));
      end
   endtask

   task automatic model_tick();
      logic rg, allow;
      if (!resetn) begin
         model_reset();
      end else begin
         rg    = !m_ins[104] || data_sram_data_ok || m_got;
         allow = !m_valid || (rg && ws_allowin);
         if (m_valid && rg && ws_allowin) begin
            m_got = 1'b0;
         end else if (m_valid && m_ins[104] && data_sram_data_ok && !m_got) begin
            m_got  = 1'b1;
            m_data = data_sram_rdata;
         end
         if (allow) begin
            m_valid = es_to_ms_valid;
            if (es_to_ms_valid) m_ins = es_to_ms_bus;
         end
      end
   endtask

   task automatic settle();
      @(negedge clk);
      check_model();
   endtask

   task automatic tick();
      @(posedge clk);
      model_tick();
      #1;
   endtask

   function automatic logic [107:0] rand_instr();
      logic [2:0] op;
      logic [1:0] alo;
      logic       req;
      op  = 3'($urandom_range(0, 7));
      alo = 2'($urandom_range(0, 3));
      if (op == 3'd3 || op == 3'd4) alo[0] = 1'b0;
      if (op == 3'd5) alo = 2'd0;
      req = (op != 3'd0) ? 1'b1 : 1'($urandom_range(0, 1));
      return mk(op, req, alo, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                $urandom, $urandom, $urandom);
   endfunction

   // one load: accept, then respond next cycle with ws_allowin high
   task automatic load_case(input string name, input logic [2:0] op, input logic [1:0] alo,
                            input logic [31:0] rt, input logic [31:0] rdata,
                            input logic [31:0] exp_res, input logic [3:0] exp_we);
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk(op, 1'b1, alo, 1'b1, 5'd9, 32'h0000_1000, rt, 32'hBFC0_0100);
      settle(); tick();
      es_to_ms_valid    = 1'b0;
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = rdata;
      settle();
      chk({name, "_res"}, 73'(ms_to_ws_bus[63:32]), 73'(exp_res));
      chk({name, "_we"}, 73'(ms_to_ws_bus[72:69]), 73'(exp_we));
      chk({name, "_valid"}, 73'(ms_to_ws_valid), 73'(1'b1));
      tick();
      data_sram_data_ok = 1'b0;
   endtask

   initial begin
      resetn = 1'b0; ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
      data_sram_data_ok = 1'b0; data_sram_rdata = '0;
      m_ins = '0; m_data = '0;
      model_reset();
      settle();
      chk("rst_allowin", 73'(ms_allowin), 73'(1'b1));
      chk("rst_valid", 73'(ms_to_ws_valid), 73'(1'b0));
      tick(); tick();
      resetn = 1'b1;

      // ALU op passes straight through
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk(3'd0, 1'b0, 2'd0, 1'b1, 5'd5, 32'h1234_5678, 32'h0, 32'hBFC0_0010);
      settle(); tick();
      es_to_ms_valid = 1'b0;
      settle();
      chk("alu_bus", ms_to_ws_bus, {4'hF, 5'd5, 32'h1234_5678, 32'hBFC0_0010});
      chk("alu_valid", 73'(ms_to_ws_valid), 73'(1'b1));
      chk("alu_fwd", 73'(forward_ms_bus[32]), 73'(1'b1));
      tick();

      load_case("lb",  3'd1, 2'd2, 32'h0, 32'h0080_0000, 32'hFFFF_FF80, 4'hF);
      load_case("lbu", 3'd2, 2'd2, 32'h0, 32'h0080_0000, 32'h0000_0080, 4'hF);
      load_case("lwl", 3'd6, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'h3344_CCDD, 4'b1100);
      load_case("lwr", 3'd7, 2'd2, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_1122, 4'b0011);

      // response delayed three cycles
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk(3'd5, 1'b1, 2'd0, 1'b1, 5'd4, 32'h0, 32'h0, 32'hBFC0_0200);
      settle(); tick();
      es_to_ms_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("wait_allowin", 73'(ms_allowin), 73'(1'b0));
         chk("wait_fwd", 73'(forward_ms_bus[32]), 73'(1'b0));
         chk("wait_stall", 73'(stall_ms_bus[5]), 73'(1'b1));
         tick();
      end
      data_sram_data_ok = 1'b1; data_sram_rdata = 32'h5555_AAAA;
      settle();
      chk("late_fwd", 73'(forward_ms_bus[32]), 73'(1'b1));
      chk("late_allowin", 73'(ms_allowin), 73'(1'b1));
      tick();
      data_sram_data_ok = 1'b0;

      // response arrives while WB is stalled; buffer holds it
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk(3'd5, 1'b1, 2'd0, 1'b1, 5'd6, 32'h0, 32'h0, 32'hBFC0_0300);
      settle(); tick();
      es_to_ms_valid = 1'b0; ws_allowin = 1'b0;
      data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
      settle();
      chk("buf_res0", 73'(ms_to_ws_bus[63:32]), 73'(32'hDEAD_BEEF));
      chk("buf_allowin0", 73'(ms_allowin), 73'(1'b0));
      tick();
      data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0123_4567;
      settle();
      chk("buf_valid", 73'(u_dut.buf_valid_q), 73'(1'b1));
      chk("buf_res1", 73'(ms_to_ws_bus[63:32]), 73'(32'hDEAD_BEEF));
      chk("buf_allowin1", 73'(ms_allowin), 73'(1'b0));
      tick();
      ws_allowin = 1'b1; data_sram_rdata = 32'h7777_0000;
      settle();
      chk("buf_leave_res", 73'(ms_to_ws_bus[63:32]), 73'(32'hDEAD_BEEF));
      chk("buf_leave_allowin", 73'(ms_allowin), 73'(1'b1));
      tick();
      settle();
      chk("buf_cleared", 73'(u_dut.buf_valid_q), 73'(1'b0));
      tick();

      // store waiting, then reset mid-wait
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk(3'd0, 1'b1, 2'd0, 1'b0, 5'd7, 32'h8000_0000, 32'h0, 32'hBFC0_0400);
      settle(); tick();
      es_to_ms_valid = 1'b0;
      settle();
      chk("store_we", 73'(ms_to_ws_bus[72:69]), 73'(4'h0));
      chk("store_valid", 73'(ms_to_ws_valid), 73'(1'b0));
      chk("store_stall", 73'(stall_ms_bus[5]), 73'(1'b0));
      tick();
      #1 resetn = 1'b0;
      model_reset();
      #1;
      chk("arst_ms_valid", 73'(u_dut.ms_valid_q), 73'(1'b0));
      chk("arst_buf_valid", 73'(u_dut.buf_valid_q), 73'(1'b0));
      chk("arst_allowin", 73'(ms_allowin), 73'(1'b1));
      chk("arst_fwd", 73'(forward_ms_bus[32]), 73'(1'b0));
      settle(); tick();
      resetn = 1'b1;

      // randomized traffic against the model
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 299) == 0) begin
            resetn = 1'b0; model_reset();
            es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b0;
            settle(); tick();
            resetn = 1'b1;
         end else begin
            es_to_ms_valid    = ($urandom_range(0, 9) < 6);
            es_to_ms_bus      = rand_instr();
            ws_allowin        = ($urandom_range(0, 9) < 7);
            data_sram_data_ok = m_valid && m_ins[104] && !m_got && ($urandom_range(0, 9) < 4);
            data_sram_rdata   = $urandom;
            settle(); tick();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage between the execute stage (upstream) and the write-back stage (downstream).
- Accepts one instruction per handshake from EX and, if that instruction issued a data-bus request in EX, waits for the data response.
- Aligns and extends load data, including the LWL/LWR merge with the old rt value, and produces the 4-bit byte write strobe for write-back.
- Drives the stall and forward buses back to decode.

Parameters:
- None. Bus widths are fixed, as listed under Ports.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- ws_allowin  in  1  write-back stage can accept.
- ms_allowin  out  1  this stage can accept from EX.
- es_to_ms_valid  in  1  EX offers an instruction.
- es_to_ms_bus  in  108  fields:
  - [107:105] load_op: 0 none, 1 lb, 2 lbu, 3 lh, 4 lhu, 5 lw, 6 lwl, 7 lwr.
  - [104] mem_req.
  - [103:102] addr_lo.
  - [101] gr_we.
  - [100:96] dest.
  - [95:64] alu_result.
  - [63:32] rt_value.
  - [31:0] pc.
- data_sram_data_ok  in  1  data-bus response strobe (read data or write ack).
- data_sram_rdata  in  32  read data, valid with data_ok.
- ms_to_ws_valid  out  1  output instruction is valid.
- ms_to_ws_bus  out  73  {gr_we[3:0] 72:69, dest 68:64, final_result 63:32, pc 31:0}.
- stall_ms_bus  out  6  {ms_valid && |ms_gr_we, dest}.
- forward_ms_bus  out  33  {ms_valid && ms_ready_go, final_result}.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (resetn).
  - resetn low clears ms_valid and buf_valid immediately.
  - The payload register is not reset.
  - During reset: ms_to_ws_valid=0, stall_ms_bus[5]=0, forward_ms_bus[32]=0, ms_allowin=1.
- Handshake:
  - ms_ready_go = !mem_req || data_sram_data_ok || buf_valid.
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - ms_to_ws_valid = ms_valid && ms_ready_go.
  - On a clock edge with ms_allowin: ms_valid <= es_to_ms_valid.
  - Payload latched only when es_to_ms_valid && ms_allowin.
- Response acceptance: data_ok is meaningful only when ms_valid && mem_req && !buf_valid. The bench asserts data_ok never arrives otherwise (one outstanding request, in order).
- Response buffer:
  - Set: ms_valid && mem_req && data_ok && !ws_allowin. Capture rdata into rdata_buf and set buf_valid.
  - Clear: ms_valid && ms_ready_go && ws_allowin (instruction leaves).
  - Set and clear are never simultaneous.
  - When buf_valid=1, the buffer is the data source.
- Data source: rd = buf_valid ? rdata_buf : data_sram_rdata. Zero latency when data_ok arrives with ws_allowin high.
- Non-memory or store (load_op=0): final_result = alu_result. Strobe 1111 if gr_we, else 0000. A store still waits for data_ok.
- Loads, with byte b = rd[8*addr_lo +: 8] and half h = rd[16*addr_lo[1] +: 16]:
  - lb: result sext(b). lbu: zext(b). lh: sext(h). lhu: zext(h). lw: rd. Strobe 1111 for all five.
- lwl, by addr_lo:
  - 0: {rd[7:0], rt[23:0]}, strobe 1000.
  - 1: {rd[15:0], rt[15:0]}, strobe 1100.
  - 2: {rd[23:0], rt[7:0]}, strobe 1110.
  - 3: rd, strobe 1111.
- lwr, by addr_lo:
  - 0: rd, strobe 1111.
  - 1: {rt[31:24], rd[31:8]}, strobe 0111.
  - 2: {rt[31:16], rd[31:16]}, strobe 0011.
  - 3: {rt[31:8], rd[31:24]}, strobe 0001.
- Output gating:
  - Output gr_we[3:0] = strobe & {4{gr_we}}.
  - dest and pc pass through.
  - Unaligned lh/lw addresses never reach this stage; behaviour for them is unspecified.
- Back-pressure with ws_allowin low: the stage holds valid, payload and buffered data. ms_allowin=0 until the instruction leaves.
- Back-to-back: a leaving instruction and a newly accepted one in the same cycle is legal. buf_valid clears on that edge.
- Reset mid-wait: an outstanding request is abandoned. The bus owner must also be reset, so no stale data_ok arrives after reset.

Test Plan:
- ALU op, alu_result=0x12345678, gr_we=1, dest=5, pc=0xBFC00010, ws_allowin=1 -> next cycle ms_to_ws_bus={4'hF,5,0x12345678,0xBFC00010}, valid=1, forward[32]=1.
- lb with addr_lo=2 and data_ok the cycle after acceptance with rdata=0x00800000 -> result 0xFFFFFF80, strobe 1111. The same with lbu -> 0x00000080.
- lwl with addr_lo=1, rt=0xAABBCCDD, rdata=0x11223344 -> result 0x3344CCDD, gr_we 1100. lwr with addr_lo=2 and the same inputs -> 0xAABB1122, gr_we 0011.
- Load with data_ok delayed 3 cycles -> ms_allowin=0, forward[32]=0, stall_ms_bus[5]=1 until the data_ok cycle.
- Load with data_ok while ws_allowin=0 for 2 cycles, rdata=0xDEADBEEF, bus changing afterwards -> buf_valid=1, output stays 0xDEADBEEF, leaves when ws_allowin rises.
- Store (gr_we=0), then resetn pulsed low mid-wait -> gr_we 0000 while waiting; ms_valid and buf_valid drop asynchronously, and ms_allowin=1 during reset.
